// File: rtl/seg7_pkg.sv
// Shared constants and the double-dabble nibble adjust for the 7-segment scheduler.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Nibbles never exceed 9 before the adjust, so the 4-bit add cannot carry out.
    function automatic logic [4*BCD_DIGITS-1:0] dabble_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [4*BCD_DIGITS-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment code; non-decimal inputs blank.
module seg7_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_scheduler.sv
// Iterative binary-to-BCD converter driving eight registered 7-segment digits.
//   state     | meaning
//   ST_IDLE   | waiting for an external or auto-refresh request; o_ready=1
//   ST_SHIFT  | 32 double-dabble steps, one input bit per clock
//   ST_UPDATE | decode BCD into o_hex*/o_ovf and pulse o_done
module seg7_bcd_scheduler
    import seg7_pkg::*;
#(
    parameter int   REFRESH_CYCLES = 0,
    parameter logic LZ_BLANK       = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_value,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ovf,
    output logic [6:0]  o_hex0,
    output logic [6:0]  o_hex1,
    output logic [6:0]  o_hex2,
    output logic [6:0]  o_hex3,
    output logic [6:0]  o_hex4,
    output logic [6:0]  o_hex5,
    output logic [6:0]  o_hex6,
    output logic [6:0]  o_hex7
);

    logic [1:0]                 state_q;
    logic [31:0]                bin_q;
    logic [4*BCD_DIGITS-1:0]    bcd_q;
    logic [4*BCD_DIGITS-1:0]    bcd_adj;
    logic [4:0]                 iter_q;
    logic                       done_q;
    logic                       ovf_q;
    logic                       ovf_d;
    logic [6:0]                 hex_q   [NUM_DIGITS];
    logic [6:0]                 hex_d   [NUM_DIGITS];
    logic [6:0]                 seg_dec [NUM_DIGITS];
    logic                       auto_req;
    logic                       accept;

    assign accept  = (state_q == ST_IDLE) && (i_valid || auto_req);
    assign bcd_adj = dabble_adjust(bcd_q);

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int            CW = $clog2(REFRESH_CYCLES + 1);
            localparam logic [CW-1:0] TC = CW'(REFRESH_CYCLES - 1);
            logic [CW-1:0] cnt_q;
            logic          req_q;

            // Request is registered one clock after the count hits TC.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cnt_q <= '0;
                    req_q <= 1'b0;
                end else if (state_q != ST_IDLE || accept) begin
                    cnt_q <= '0;
                    req_q <= 1'b0;
                end else if (cnt_q == TC) begin
                    req_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign auto_req = req_q;
        end else begin : g_no_refresh
            assign auto_req = 1'b0;
        end
    endgenerate

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_digit_decoder u_dec (
            .digit_i (bcd_q[4*g +: 4]),
            .seg_o   (seg_dec[g])
        );
    end

    // lead_zero tracks "this digit and every digit above it are zero".
    always_comb begin
        logic lead_zero;
        ovf_d     = |bcd_q[4*BCD_DIGITS-1:4*NUM_DIGITS];
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
            if (ovf_d) begin
                hex_d[i] = SEG_DASH;
            end else if (LZ_BLANK && (i != 0) && lead_zero) begin
                hex_d[i] = SEG_BLANK;
            end else begin
                hex_d[i] = seg_dec[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        bin_q   <= i_value;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
                    iter_q         <= iter_q + 5'd1;
                    if (iter_q == 5'd31) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hex_q   <= hex_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;
    assign o_ovf   = ovf_q;
    assign o_hex0  = hex_q[0];
    assign o_hex1  = hex_q[1];
    assign o_hex2  = hex_q[2];
    assign o_hex3  = hex_q[3];
    assign o_hex4  = hex_q[4];
    assign o_hex5  = hex_q[5];
    assign o_hex6  = hex_q[6];
    assign o_hex7  = hex_q[7];

endmodule

// File: tb/tb_seg7_bcd_scheduler.sv
// Scoreboard bench: dut_a (no blanking), dut_b (blanking) share stimulus; dut_c auto-refreshes.
module tb_seg7_bcd_scheduler;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    typedef struct {
        logic [55:0] hex;
        logic        ovf;
        int          due;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ab, rst_c;
    logic [31:0] value_ab, value_c;
    logic        valid_ab, valid_c;

    logic        a_ready, a_busy, a_done, a_ovf;
    logic        b_ready, b_busy, b_done, b_ovf;
    logic        c_ready, c_busy, c_done, c_ovf;
    logic [6:0]  a_h0, a_h1, a_h2, a_h3, a_h4, a_h5, a_h6, a_h7;
    logic [6:0]  b_h0, b_h1, b_h2, b_h3, b_h4, b_h5, b_h6, b_h7;
    logic [6:0]  c_h0, c_h1, c_h2, c_h3, c_h4, c_h5, c_h6, c_h7;

    wire [55:0] hx_a = {a_h7, a_h6, a_h5, a_h4, a_h3, a_h2, a_h1, a_h0};
    wire [55:0] hx_b = {b_h7, b_h6, b_h5, b_h4, b_h3, b_h2, b_h1, b_h0};
    wire [55:0] hx_c = {c_h7, c_h6, c_h5, c_h4, c_h3, c_h2, c_h1, c_h0};

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   last_c = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_bcd_scheduler #(.REFRESH_CYCLES(0), .LZ_BLANK(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst_ab), .i_value(value_ab), .i_valid(valid_ab),
        .o_ready(a_ready), .o_busy(a_busy), .o_done(a_done), .o_ovf(a_ovf),
        .o_hex0(a_h0), .o_hex1(a_h1), .o_hex2(a_h2), .o_hex3(a_h3),
        .o_hex4(a_h4), .o_hex5(a_h5), .o_hex6(a_h6), .o_hex7(a_h7));

    seg7_bcd_scheduler #(.REFRESH_CYCLES(0), .LZ_BLANK(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst_ab), .i_value(value_ab), .i_valid(valid_ab),
        .o_ready(b_ready), .o_busy(b_busy), .o_done(b_done), .o_ovf(b_ovf),
        .o_hex0(b_h0), .o_hex1(b_h1), .o_hex2(b_h2), .o_hex3(b_h3),
        .o_hex4(b_h4), .o_hex5(b_h5), .o_hex6(b_h6), .o_hex7(b_h7));

    seg7_bcd_scheduler #(.REFRESH_CYCLES(50), .LZ_BLANK(1'b1)) dut_c (
        .i_clk(clk), .i_rst(rst_c), .i_value(value_c), .i_valid(valid_c),
        .o_ready(c_ready), .o_busy(c_busy), .o_done(c_done), .o_ovf(c_ovf),
        .o_hex0(c_h0), .o_hex1(c_h1), .o_hex2(c_h2), .o_hex3(c_h3),
        .o_hex4(c_h4), .o_hex5(c_h5), .o_hex6(c_h6), .o_hex7(c_h7));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input logic [55:0] hx, input logic ovf, input exp_t e);
        chk({tag, "_hex"}, {8'h0, hx}, {8'h0, e.hex});
        chk({tag, "_ovf"}, {63'h0, ovf}, {63'h0, e.ovf});
        if (e.due != 0) chk({tag, "_latency_cycle"}, 64'(cyc), 64'(e.due));
    endtask

    // Monitors: pop one expectation per o_done pulse.
    initial forever begin
        @(negedge clk);
        if (a_done) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
            else score("a", hx_a, a_ovf, q_a.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (b_done) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
            else score("b", hx_b, b_ovf, q_b.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (c_done) begin
            exp_t e;
            if (q_c.size() == 0) chk("c_unexpected_done", 64'd1, 64'd0);
            else begin
                e = q_c.pop_front();
                score("c", hx_c, c_ovf, e);
                if (e.gap != 0) chk("c_refresh_period", 64'(cyc - last_c), 64'(e.gap));
            end
            last_c = cyc;
        end
    end

    task automatic send(input logic [31:0] v, input logic [55:0] ea, input logic [55:0] eb,
                        input logic eo, input logic push, output int e0);
        int   n;
        exp_t e;
        n  = 0;
        e0 = 0;
        @(negedge clk);
        while (!a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            chk("send_ready_timeout", 64'd0, 64'd1);
            return;
        end
        value_ab = v;
        valid_ab = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (push) begin
            e.ovf = eo; e.due = cyc + 33; e.gap = 0;
            e.hex = ea; q_a.push_back(e);
            e.hex = eb; q_b.push_back(e);
        end
        @(negedge clk);
        valid_ab = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_pending"}, 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1;
        exp_t ec;
        rst_ab = 1'b1; rst_c = 1'b1;
        value_ab = '0; valid_ab = 1'b0;
        value_c = 32'd7; valid_c = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hex_a", {8'h0, hx_a}, {8'h0, {8{SB}}});
        chk("rst_hex_b", {8'h0, hx_b}, {8'h0, {8{SB}}});
        chk("rst_ready_busy_done_ovf", {60'h0, a_ready, a_busy, a_done, a_ovf}, {60'h0, 4'b1000});
        rst_ab = 1'b0;

        send(32'd12_345_678, {S1,S2,S3,S4,S5,S6,S7,S8}, {S1,S2,S3,S4,S5,S6,S7,S8}, 1'b0, 1'b1, e0);
        drain("v12345678");
        send(32'd42, {S0,S0,S0,S0,S0,S0,S4,S2}, {SB,SB,SB,SB,SB,SB,S4,S2}, 1'b0, 1'b1, e0);
        send(32'd0, {8{S0}}, {{7{SB}}, S0}, 1'b0, 1'b1, e1);
        chk("back_to_back_spacing", 64'(e1 - e0), 64'd34);
        send(32'hFFFF_FFFF, {8{SD}}, {8{SD}}, 1'b1, 1'b1, e0);
        send(32'd99_999_999, {8{S9}}, {8{S9}}, 1'b0, 1'b1, e0);
        send(32'd100_000_000, {8{SD}}, {8{SD}}, 1'b1, 1'b1, e0);
        send(32'd10_000_000, {S1, {7{S0}}}, {S1, {7{S0}}}, 1'b0, 1'b1, e0);
        drain("vectors");

        // Request while busy must be dropped, and the late i_value change must not leak in.
        send(32'd5, {{7{S0}}, S5}, {{7{SB}}, S5}, 1'b0, 1'b1, e0);
        repeat (9) @(negedge clk);
        chk("busy_mid_conversion", {62'h0, a_busy, a_ready}, {62'h0, 2'b10});
        value_ab = 32'd7;
        valid_ab = 1'b1;
        @(negedge clk);
        valid_ab = 1'b0;
        drain("busy_ignore");
        repeat (40) @(negedge clk);

        // Reset in the middle of a conversion: blank outputs and no o_done.
        send(32'd12_345_678, '0, '0, 1'b0, 1'b0, e0);
        repeat (19) @(negedge clk);
        rst_ab = 1'b1;
        @(negedge clk);
        rst_ab = 1'b0;
        chk("midrst_hex_a", {8'h0, hx_a}, {8'h0, {8{SB}}});
        chk("midrst_hex_b", {8'h0, hx_b}, {8'h0, {8{SB}}});
        chk("midrst_ready_busy_done_ovf", {60'h0, a_ready, a_busy, a_done, a_ovf}, {60'h0, 4'b1000});
        repeat (50) @(negedge clk);
        chk("midrst_still_blank", {8'h0, hx_a}, {8'h0, {8{SB}}});

        // Auto-refresh instance.
        chk("c_rst_busy", {63'h0, c_busy}, 64'd0);
        ec.hex = {{7{SB}}, S7}; ec.ovf = 1'b0; ec.due = 0; ec.gap = 0;
        q_c.push_back(ec);
        rst_c = 1'b0;
        drain("refresh_first");
        value_c = 32'd9;
        ec.hex = {{7{SB}}, S9}; ec.gap = 84;
        q_c.push_back(ec);
        q_c.push_back(ec);
        drain("refresh_periodic");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
